// File: rtl/l2_port_scheduler.sv
// l2_port_scheduler: arbitrates icache, dcache and prefetcher line requests
// onto a single L2 port. One transfer in flight at a time; IDLE -> BUSY -> DONE.
//
// Handshake: a requester holds its read/write level (and address/data) until
// its resp pulse. The resp pulse is the only completion indication and lasts
// one cycle, coincident with l2_resp. The L2 side sees l2_read/l2_write held
// high for the whole BUSY phase; l2_resp in BUSY completes the transfer.
// Requester inputs are sampled only on the IDLE decision edge.
module l2_port_scheduler #(
  parameter int s_line       = 256,
  parameter int STARVE_LIMIT = 4,
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  // icache
  input  logic              ic_read,
  input  logic [31:0]       ic_address,
  output logic              ic_resp,
  output logic [s_line-1:0] ic_rdata,
  // dcache
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [31:0]       dc_address,
  input  logic [s_line-1:0] dc_wdata,
  output logic              dc_resp,
  output logic [s_line-1:0] dc_rdata,
  // prefetcher
  input  logic              pf_read,
  input  logic [31:0]       pf_address,
  output logic              pf_resp,
  output logic [s_line-1:0] pf_rdata,
  // L2
  output logic              l2_read,
  output logic              l2_write,
  output logic [31:0]       l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [s_line-1:0] l2_rdata,
  // debug visibility of internal state
  output logic [1:0]        o_dbg_state,
  output logic [1:0]        o_dbg_grant,
  output logic [1:0]        o_dbg_rr_ptr,
  output logic [SW-1:0]     o_dbg_starve_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IC   = 2'd1,
    GNT_DC   = 2'd2,
    GNT_PF   = 2'd3
  } grant_t;

  state_t            r_state, w_state_nxt;
  grant_t            r_grant, w_grant_nxt;
  grant_t            r_rr_ptr, w_rr_nxt;
  logic [SW-1:0]     r_starve_cnt, w_starve_nxt;
  logic              r_is_write, w_is_write_nxt;
  logic [31:0]       r_addr, w_addr_nxt;
  logic [s_line-1:0] r_wdata, w_wdata_nxt;

  grant_t            w_winner;
  logic              w_dc_req;
  logic              w_pf_starved;
  logic              w_busy;
  logic              w_complete;

  // Winner selection for the IDLE decision: starved PF first, then IC/DC
  // (round-robin when both), then PF as the lowest-priority requester.
  always_comb begin
    w_winner     = GNT_NONE;
    w_dc_req     = dc_read | dc_write;
    w_pf_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
    if (pf_read && w_pf_starved) begin
      w_winner = GNT_PF;
    end else if (ic_read && w_dc_req) begin
      w_winner = r_rr_ptr;
    end else if (ic_read) begin
      w_winner = GNT_IC;
    end else if (w_dc_req) begin
      w_winner = GNT_DC;
    end else if (pf_read) begin
      w_winner = GNT_PF;
    end
  end

  // Next-state logic: FSM, grant, fairness state and latched L2 request.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_nxt       = r_rr_ptr;
    w_starve_nxt   = r_starve_cnt;
    w_is_write_nxt = r_is_write;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = w_winner;
        // PF starvation only accrues while PF is actually asking and loses.
        if (!pf_read || w_winner == GNT_PF) begin
          w_starve_nxt = '0;
        end else if (!w_pf_starved) begin
          w_starve_nxt = r_starve_cnt + SW'(1);
        end
        case (w_winner)
          GNT_IC: begin
            w_state_nxt    = ST_BUSY;
            w_is_write_nxt = 1'b0;
            w_addr_nxt     = ic_address;
            w_wdata_nxt    = '0;
            w_rr_nxt       = GNT_DC;
          end
          GNT_DC: begin
            w_state_nxt    = ST_BUSY;
            w_is_write_nxt = dc_write;  // read+write together is a write
            w_addr_nxt     = dc_address;
            w_wdata_nxt    = dc_wdata;
            w_rr_nxt       = GNT_IC;
          end
          GNT_PF: begin
            w_state_nxt    = ST_BUSY;
            w_is_write_nxt = 1'b0;
            w_addr_nxt     = pf_address;
            w_wdata_nxt    = '0;
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
      ST_BUSY: begin
        if (l2_resp) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = GNT_NONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = GNT_NONE;
      end
    endcase
  end

  // State registers; asynchronous reset abandons any in-flight transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= GNT_NONE;
      r_rr_ptr     <= GNT_IC;
      r_starve_cnt <= '0;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_is_write   <= w_is_write_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
    end
  end

  // L2 request and same-cycle completion routing to the granted requester.
  always_comb begin
    w_busy     = (r_state == ST_BUSY);
    w_complete = w_busy & l2_resp;
    l2_read    = w_busy & ~r_is_write;
    l2_write   = w_busy & r_is_write;
    l2_address = r_addr;
    l2_wdata   = r_wdata;
    ic_resp    = w_complete & (r_grant == GNT_IC);
    dc_resp    = w_complete & (r_grant == GNT_DC);
    pf_resp    = w_complete & (r_grant == GNT_PF);
    ic_rdata   = ic_resp ? l2_rdata : '0;
    dc_rdata   = dc_resp ? l2_rdata : '0;
    pf_rdata   = pf_resp ? l2_rdata : '0;
  end

  assign o_dbg_state      = r_state;
  assign o_dbg_grant      = r_grant;
  assign o_dbg_rr_ptr     = r_rr_ptr;
  assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Directed testbench for l2_port_scheduler (default parameters).
module tb_l2_port_scheduler;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] G_NONE  = 2'd0;
  localparam logic [1:0] G_IC    = 2'd1;
  localparam logic [1:0] G_DC    = 2'd2;
  localparam logic [1:0] G_PF    = 2'd3;

  logic         clk;
  logic         rst_n;
  logic         ic_read;
  logic [31:0]  ic_address;
  logic         ic_resp;
  logic [255:0] ic_rdata;
  logic         dc_read;
  logic         dc_write;
  logic [31:0]  dc_address;
  logic [255:0] dc_wdata;
  logic         dc_resp;
  logic [255:0] dc_rdata;
  logic         pf_read;
  logic [31:0]  pf_address;
  logic         pf_resp;
  logic [255:0] pf_rdata;
  logic         l2_read;
  logic         l2_write;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata;
  logic         l2_resp;
  logic [255:0] l2_rdata;
  logic [1:0]   dbg_state;
  logic [1:0]   dbg_grant;
  logic [1:0]   dbg_rr_ptr;
  logic [2:0]   dbg_starve;

  int n_tests = 0;
  int n_fail  = 0;

  l2_port_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ic_read          (ic_read),
    .ic_address       (ic_address),
    .ic_resp          (ic_resp),
    .ic_rdata         (ic_rdata),
    .dc_read          (dc_read),
    .dc_write         (dc_write),
    .dc_address       (dc_address),
    .dc_wdata         (dc_wdata),
    .dc_resp          (dc_resp),
    .dc_rdata         (dc_rdata),
    .pf_read          (pf_read),
    .pf_address       (pf_address),
    .pf_resp          (pf_resp),
    .pf_rdata         (pf_rdata),
    .l2_read          (l2_read),
    .l2_write         (l2_write),
    .l2_address       (l2_address),
    .l2_wdata         (l2_wdata),
    .l2_resp          (l2_resp),
    .l2_rdata         (l2_rdata),
    .o_dbg_state      (dbg_state),
    .o_dbg_grant      (dbg_grant),
    .o_dbg_rr_ptr     (dbg_rr_ptr),
    .o_dbg_starve_cnt (dbg_starve)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_read    = 1'b0;
    ic_address = '0;
    dc_read    = 1'b0;
    dc_write   = 1'b0;
    dc_address = '0;
    dc_wdata   = '0;
    pf_read    = 1'b0;
    pf_address = '0;
    l2_resp    = 1'b0;
    l2_rdata   = '0;
  endtask

  // Hold reset for two edges, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called right after the edge that entered BUSY. Checks the L2 request for
  // busy_cycles cycles, answers it, then checks DONE and the return to IDLE.
  task automatic serve(input string tag, input logic [1:0] exp_g, input logic exp_wr,
                       input logic [31:0] exp_addr, input int busy_cycles,
                       input logic [255:0] rdata);
    chk({tag, ".state_busy"}, dbg_state, ST_BUSY);
    chk({tag, ".grant"}, dbg_grant, exp_g);
    for (int c = 0; c < busy_cycles; c++) begin
      if (c > 0) tick();
      chk({tag, ".l2_read"}, l2_read, !exp_wr);
      chk({tag, ".l2_write"}, l2_write, exp_wr);
      chk({tag, ".l2_address"}, l2_address, exp_addr);
      chk({tag, ".no_resp_yet"}, {ic_resp, dc_resp, pf_resp}, 3'b000);
    end
    l2_rdata = rdata;
    l2_resp  = 1'b1;
    #1;
    chk({tag, ".ic_resp"}, ic_resp, exp_g == G_IC);
    chk({tag, ".dc_resp"}, dc_resp, exp_g == G_DC);
    chk({tag, ".pf_resp"}, pf_resp, exp_g == G_PF);
    chk({tag, ".ic_rdata"}, ic_rdata, (exp_g == G_IC) ? rdata : 256'd0);
    chk({tag, ".dc_rdata"}, dc_rdata, (exp_g == G_DC) ? rdata : 256'd0);
    chk({tag, ".pf_rdata"}, pf_rdata, (exp_g == G_PF) ? rdata : 256'd0);
    tick();
    l2_resp  = 1'b0;
    l2_rdata = '0;
    #1;
    chk({tag, ".state_done"}, dbg_state, ST_DONE);
    chk({tag, ".done_no_req"}, {l2_read, l2_write}, 2'b00);
    chk({tag, ".done_no_resp"}, {ic_resp, dc_resp, pf_resp}, 3'b000);
    tick();
    chk({tag, ".state_idle"}, dbg_state, ST_IDLE);
    chk({tag, ".grant_none"}, dbg_grant, G_NONE);
  endtask

  initial begin
    logic [255:0] line_a5;
    line_a5 = {32{8'hA5}};

    // ---- Reset state, with noisy inputs held during reset ----
    rst_n = 1'b0;
    clear_inputs();
    ic_read = 1'b1;
    dc_read = 1'b1;
    pf_read = 1'b1;
    l2_resp = 1'b1;
    #3;
    chk("rst.state_async", dbg_state, ST_IDLE);
    tick();
    tick();
    chk("rst.state", dbg_state, ST_IDLE);
    chk("rst.grant", dbg_grant, G_NONE);
    chk("rst.rr_ptr", dbg_rr_ptr, G_IC);
    chk("rst.starve", dbg_starve, 3'd0);
    chk("rst.l2_req", {l2_read, l2_write}, 2'b00);
    chk("rst.l2_address", l2_address, 32'd0);
    chk("rst.l2_wdata", l2_wdata, 256'd0);
    chk("rst.resp", {ic_resp, dc_resp, pf_resp}, 3'b000);

    // ---- IC read alone, 3 BUSY cycles; first decision on first edge ----
    clear_inputs();
    @(negedge clk);
    rst_n      = 1'b1;
    ic_read    = 1'b1;
    ic_address = 32'h0000_1000;
    tick();
    ic_read = 1'b0;
    chk("ic_alone.rr_ptr", dbg_rr_ptr, G_DC);
    serve("ic_alone", G_IC, 1'b0, 32'h0000_1000, 3, {8{32'hCAFE_0001}});

    // ---- l2_resp while IDLE is ignored ----
    l2_resp  = 1'b1;
    l2_rdata = {8{32'h1234_5678}};
    #1;
    chk("idle_resp.resp", {ic_resp, dc_resp, pf_resp}, 3'b000);
    chk("idle_resp.ic_rdata", ic_rdata, 256'd0);
    tick();
    chk("idle_resp.state", dbg_state, ST_IDLE);
    l2_resp  = 1'b0;
    l2_rdata = '0;

    // ---- IC and DC both continuously requesting from reset ----
    do_reset();
    ic_read    = 1'b1;
    ic_address = 32'h0000_0100;
    dc_read    = 1'b1;
    dc_address = 32'h0000_0200;
    for (int g = 0; g < 4; g++) begin
      tick();
      if (g % 2 == 0)
        serve($sformatf("rr%0d", g), G_IC, 1'b0, 32'h0000_0100, 1, {8{32'h0000_AA00}} | 256'(g));
      else
        serve($sformatf("rr%0d", g), G_DC, 1'b0, 32'h0000_0200, 1, {8{32'h0000_BB00}} | 256'(g));
    end
    clear_inputs();

    // ---- PF starvation: all three requesting ----
    do_reset();
    ic_read    = 1'b1;
    ic_address = 32'h0000_0100;
    dc_read    = 1'b1;
    dc_address = 32'h0000_0200;
    pf_read    = 1'b1;
    pf_address = 32'h0000_9000;
    begin
      logic [1:0]  exp_g [6];
      logic [2:0]  exp_s [6];
      logic [31:0] exp_a [6];
      exp_g = '{G_IC, G_DC, G_IC, G_DC, G_PF, G_IC};
      exp_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
      exp_a = '{32'h100, 32'h200, 32'h100, 32'h200, 32'h9000, 32'h100};
      for (int n = 0; n < 6; n++) begin
        tick();
        chk($sformatf("starve%0d.cnt", n + 1), dbg_starve, exp_s[n]);
        serve($sformatf("starve%0d", n + 1), exp_g[n], 1'b0, exp_a[n], 1, {8{32'h5000_0000}} | 256'(n));
      end
    end
    // PF drops its request: counter clears on the next IDLE decision
    pf_read = 1'b0;
    dc_read = 1'b0;
    tick();
    chk("starve_clear.cnt", dbg_starve, 3'd0);
    serve("starve_clear", G_IC, 1'b0, 32'h0000_0100, 1, {8{32'h7777_0000}});
    clear_inputs();

    // ---- DC read+write together is a write ----
    dc_read    = 1'b1;
    dc_write   = 1'b1;
    dc_address = 32'h0000_2000;
    dc_wdata   = line_a5;
    tick();
    clear_inputs();
    chk("dc_rw.l2_wdata", l2_wdata, line_a5);
    serve("dc_rw", G_DC, 1'b1, 32'h0000_2000, 2, {8{32'h0BAD_F00D}});

    // ---- Inputs changing during BUSY do not affect the L2 request ----
    dc_read    = 1'b1;
    dc_address = 32'h0000_3000;
    tick();
    dc_address = 32'h0000_4000;
    dc_write   = 1'b1;
    dc_wdata   = line_a5;
    ic_read    = 1'b1;
    tick();
    chk("busy_change.state", dbg_state, ST_BUSY);
    chk("busy_change.l2_wdata", l2_wdata, 256'd0);
    serve("busy_change", G_DC, 1'b0, 32'h0000_3000, 2, {8{32'h3000_3000}});
    clear_inputs();

    // ---- Reset during BUSY abandons the transfer ----
    ic_read    = 1'b1;
    ic_address = 32'h0000_5000;
    tick();
    chk("rst_busy.l2_read_before", l2_read, 1'b1);
    ic_read = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy.l2_read", l2_read, 1'b0);
    chk("rst_busy.l2_address", l2_address, 32'd0);
    chk("rst_busy.state", dbg_state, ST_IDLE);
    chk("rst_busy.grant", dbg_grant, G_NONE);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    l2_resp  = 1'b1;
    l2_rdata = {8{32'hDEAD_BEEF}};
    #1;
    chk("rst_busy.late_resp", {ic_resp, dc_resp, pf_resp}, 3'b000);
    tick();
    chk("rst_busy.late_state", dbg_state, ST_IDLE);
    l2_resp    = 1'b0;
    l2_rdata   = '0;
    dc_read    = 1'b1;
    dc_address = 32'h0000_6000;
    tick();
    dc_read = 1'b0;
    serve("rst_busy.next", G_DC, 1'b0, 32'h0000_6000, 1, {8{32'h6000_0006}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
